// File: rtl/dcache_write_buffer.sv
// Posted-write FIFO between the data cache and data_memory: absorbs write-backs, drains them in order,
// forwards buffered data to cache reads and lets read misses go to memory ahead of further drains.
module dcache_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              c_read,
    input  logic              c_write,
    input  logic [ADDR_W-1:0] c_address,
    input  logic [DATA_W-1:0] c_writedata,
    output logic [DATA_W-1:0] c_readdata,
    output logic              c_busywait,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata,
    input  logic              mem_busywait
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] DRAIN     = 2'd1;
    localparam logic [1:0] MEM_READ  = 2'd2;
    localparam logic [1:0] READ_DONE = 2'd3;

    logic [1:0]        state;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] rd_q;

    logic              hit;
    logic [DATA_W-1:0] hit_data;
    logic              co_hit;
    logic [PTR_W-1:0]  co_idx;
    logic [PTR_W-1:0]  idx;
    logic              pop;
    logic              miss;
    logic              wr_acc;
    logic              append;
    logic [DATA_W-1:0] head_data;

    // Scan oldest to newest so the last match is the newest copy of an address.
    // The draining head is visible to reads but must not be coalesced into.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        co_hit   = 1'b0;
        co_idx   = '0;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PTR_W'(k);
            if ((CNT_W'(k) < count) && (addr_q[idx] == c_address)) begin
                hit      = 1'b1;
                hit_data = data_q[idx];
                if (!(k == 0 && state == DRAIN)) begin
                    co_hit = 1'b1;
                    co_idx = idx;
                end
            end
        end
    end

    assign pop    = (state == DRAIN) && !mem_busywait;
    assign miss   = c_read && !hit;
    assign wr_acc = c_write && !c_read && ((count < CNT_W'(DEPTH)) || pop);
    assign append = wr_acc && !co_hit;

    // A coalesce into the head on the same edge a drain starts must reach memory.
    assign head_data = (wr_acc && co_hit && co_idx == head) ? c_writedata : data_q[head];

    assign c_busywait = c_read ? !(hit || state == READ_DONE) : (c_write && !wr_acc);
    assign c_readdata = (c_read && hit) ? hit_data : rd_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state         <= IDLE;
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            rd_q          <= '0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_address   <= '0;
            mem_writedata <= '0;
        end else begin
            if (append) begin
                addr_q[tail] <= c_address;
                data_q[tail] <= c_writedata;
                tail         <= tail + 1'b1;
            end
            if (wr_acc && co_hit) begin
                data_q[co_idx] <= c_writedata;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            if (append && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !append) begin
                count <= count - 1'b1;
            end

            case (state)
                IDLE: begin
                    if (miss) begin
                        state       <= MEM_READ;
                        mem_read    <= 1'b1;
                        mem_address <= c_address;
                    end else if (count != '0) begin
                        state         <= DRAIN;
                        mem_write     <= 1'b1;
                        mem_address   <= addr_q[head];
                        mem_writedata <= head_data;
                    end
                end
                DRAIN: begin
                    if (pop) begin
                        mem_write <= 1'b0;
                        if (miss) begin
                            state       <= MEM_READ;
                            mem_read    <= 1'b1;
                            mem_address <= c_address;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                MEM_READ: begin
                    if (!mem_busywait) begin
                        rd_q     <= mem_readdata;
                        mem_read <= 1'b0;
                        state    <= READ_DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_write_buffer.sv
// Directed bench for dcache_write_buffer with a behavioural data_memory of configurable latency.
module tb_dcache_write_buffer;
    logic        CLK = 1'b0;
    logic        RESET;
    logic        c_read, c_write;
    logic [5:0]  c_address;
    logic [31:0] c_writedata;
    logic [31:0] c_readdata;
    logic        c_busywait;
    logic        mem_read, mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_busywait;

    int checks = 0;
    int errors = 0;

    logic        hold_busy;
    int          lat;
    int          wcnt;
    logic [31:0] memarr [64];
    logic [5:0]  log_addr [$];
    logic [31:0] log_data [$];
    logic        rd_seen, both_seen;

    dcache_write_buffer #(.DEPTH(4), .ADDR_W(6), .DATA_W(32)) dut (
        .CLK(CLK), .RESET(RESET),
        .c_read(c_read), .c_write(c_write), .c_address(c_address),
        .c_writedata(c_writedata), .c_readdata(c_readdata), .c_busywait(c_busywait),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
    );

    always #5 CLK = ~CLK;

    // Memory stays busy for lat cycles of each request, or indefinitely while hold_busy is set.
    assign mem_busywait = hold_busy || ((mem_read || mem_write) && (wcnt < lat));
    assign mem_readdata = memarr[mem_address];

    always @(posedge CLK) begin
        if (RESET) begin
            wcnt <= 0;
        end else if (mem_read || mem_write) begin
            if (!mem_busywait) begin
                wcnt <= 0;
                if (mem_write) begin
                    memarr[mem_address] <= mem_writedata;
                    log_addr.push_back(mem_address);
                    log_data.push_back(mem_writedata);
                end
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            wcnt <= 0;
        end
    end

    always @(negedge CLK) begin
        if (mem_read) rd_seen = 1'b1;
        if (mem_read && mem_write) both_seen = 1'b1;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        c_write = 1'b1; c_read = 1'b0; c_address = a; c_writedata = d;
        #1;
    endtask

    task automatic drain_all();
        int n = 0;
        c_read = 1'b0; c_write = 1'b0; hold_busy = 1'b0;
        while ((dut.count != 3'd0 || dut.state != 2'd0) && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 200) begin errors++; $display("FAIL drain_timeout: count=%0d state=%0d, want 0 0", dut.count, dut.state); end
    endtask

    task automatic test_reset();
        RESET = 1'b1; tick(); tick(); RESET = 1'b0; #1;
        checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL reset_mem_read: got %0b want 0", mem_read); end
        checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL reset_mem_write: got %0b want 0", mem_write); end
        checks++; if (mem_address !== 6'h0) begin errors++; $display("FAIL reset_mem_address: got %h want 00", mem_address); end
        checks++; if (mem_writedata !== 32'h0) begin errors++; $display("FAIL reset_mem_writedata: got %h want 0", mem_writedata); end
        checks++; if (c_readdata !== 32'h0) begin errors++; $display("FAIL reset_c_readdata: got %h want 0", c_readdata); end
        checks++; if (c_busywait !== 1'b0) begin errors++; $display("FAIL reset_busywait: got %0b want 0", c_busywait); end
        checks++; if (dut.count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", dut.count); end
    endtask

    task automatic test_single_write();
        int n = 0;
        hold_busy = 1'b0; lat = 4;
        wr(6'h05, 32'hAABBCCDD);
        checks++; if (c_busywait !== 1'b0) begin errors++; $display("FAIL single_accept: busywait=%0b want 0", c_busywait); end
        tick(); c_write = 1'b0;
        tick();
        checks++; if (mem_write !== 1'b1 || mem_address !== 6'h05 || mem_writedata !== 32'hAABBCCDD) begin
            errors++; $display("FAIL single_issue: w=%0b a=%h d=%h want 1 05 aabbccdd", mem_write, mem_address, mem_writedata); end
        while (dut.count != 3'd0 && n < 50) begin tick(); n++; end
        checks++; if (n !== 5) begin errors++; $display("FAIL single_latency: drain cycles %0d want 5", n); end
        checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL single_drop: mem_write=%0b want 0", mem_write); end
        checks++; if (log_addr[$] !== 6'h05 || log_data[$] !== 32'hAABBCCDD) begin
            errors++; $display("FAIL single_mem: got %h=%h want 05=aabbccdd", log_addr[$], log_data[$]); end
        drain_all();
    endtask

    task automatic test_full();
        int ln0 = log_addr.size();
        hold_busy = 1'b1; lat = 0;
        for (int i = 1; i <= 4; i++) begin
            wr(6'(i), 32'h1000_0000 + i);
            checks++; if (c_busywait !== 1'b0) begin errors++; $display("FAIL full_accept%0d: busywait=%0b want 0", i, c_busywait); end
            tick();
        end
        wr(6'h05, 32'h1000_0005);
        checks++; if (c_busywait !== 1'b1) begin errors++; $display("FAIL full_stall0: busywait=%0b want 1", c_busywait); end
        tick();
        checks++; if (c_busywait !== 1'b1) begin errors++; $display("FAIL full_stall1: busywait=%0b want 1", c_busywait); end
        checks++; if (dut.count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d want 4", dut.count); end
        hold_busy = 1'b0; #1;
        checks++; if (c_busywait !== 1'b0) begin errors++; $display("FAIL full_pop_accept: busywait=%0b want 0", c_busywait); end
        tick(); c_write = 1'b0;
        checks++; if (dut.count !== 3'd4) begin errors++; $display("FAIL full_pop_count: got %0d want 4", dut.count); end
        drain_all();
        checks++; if (log_addr.size() - ln0 !== 5) begin errors++; $display("FAIL full_nwrites: got %0d want 5", log_addr.size() - ln0); end
        else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (log_addr[ln0+i] !== 6'(i+1) || log_data[ln0+i] !== 32'h1000_0001 + i) begin
                    errors++; $display("FAIL full_order%0d: got %h=%h want %h", i, log_addr[ln0+i], log_data[ln0+i], i+1); end
            end
        end
    endtask

    task automatic test_coalesce();
        int ln0 = log_addr.size();
        int n10 = 0;
        logic [31:0] d10 = 32'h0;
        hold_busy = 1'b1;
        wr(6'h0F, 32'h0F0F0F0F); tick();
        wr(6'h10, 32'h11111111); tick();
        wr(6'h10, 32'h22222222);
        checks++; if (c_busywait !== 1'b0) begin errors++; $display("FAIL coal_accept: busywait=%0b want 0", c_busywait); end
        tick(); c_write = 1'b0;
        checks++; if (dut.count !== 3'd2) begin errors++; $display("FAIL coal_count: got %0d want 2", dut.count); end
        checks++; if (mem_write !== 1'b1 || mem_address !== 6'h0F) begin errors++; $display("FAIL coal_head: w=%0b a=%h want 1 0f", mem_write, mem_address); end
        drain_all();
        for (int i = ln0; i < log_addr.size(); i++) if (log_addr[i] == 6'h10) begin n10++; d10 = log_data[i]; end
        checks++; if (n10 !== 1 || d10 !== 32'h22222222) begin errors++; $display("FAIL coal_mem: %0d writes data %h want 1 22222222", n10, d10); end
    endtask

    task automatic test_read_hit();
        hold_busy = 1'b1; rd_seen = 1'b0;
        wr(6'h07, 32'hDEADBEEF); tick(); c_write = 1'b0; tick();
        c_read = 1'b1; c_address = 6'h07; #1;
        checks++; if (c_readdata !== 32'hDEADBEEF || c_busywait !== 1'b0) begin
            errors++; $display("FAIL hit_head: data=%h busy=%0b want deadbeef 0", c_readdata, c_busywait); end
        tick(); c_read = 1'b0;
        wr(6'h07, 32'h12345678); tick(); c_write = 1'b0;
        checks++; if (dut.count !== 3'd2) begin errors++; $display("FAIL hit_dup_count: got %0d want 2", dut.count); end
        c_read = 1'b1; c_address = 6'h07; #1;
        checks++; if (c_readdata !== 32'h12345678 || c_busywait !== 1'b0) begin
            errors++; $display("FAIL hit_newest: data=%h busy=%0b want 12345678 0", c_readdata, c_busywait); end
        tick(); c_read = 1'b0;
        checks++; if (rd_seen !== 1'b0) begin errors++; $display("FAIL hit_no_memread: mem_read seen=%0b want 0", rd_seen); end
        drain_all();
        checks++; if (memarr[7] !== 32'h12345678) begin errors++; $display("FAIL hit_final_mem: got %h want 12345678", memarr[7]); end
    endtask

    task automatic test_read_miss();
        int ln0;
        int n = 0;
        memarr[32] = 32'hCAFEF00D;
        hold_busy = 1'b1; lat = 2;
        wr(6'h03, 32'h33333333); tick();
        wr(6'h04, 32'h44444444); tick(); c_write = 1'b0;
        tick();
        checks++; if (mem_write !== 1'b1 || mem_address !== 6'h03) begin errors++; $display("FAIL miss_drain: w=%0b a=%h want 1 03", mem_write, mem_address); end
        ln0 = log_addr.size();
        c_read = 1'b1; c_address = 6'h20; #1;
        checks++; if (c_busywait !== 1'b1) begin errors++; $display("FAIL miss_busy: got %0b want 1", c_busywait); end
        tick();
        checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL miss_wait_write: mem_read=%0b want 0", mem_read); end
        hold_busy = 1'b0;
        tick();
        checks++; if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_address !== 6'h20) begin
            errors++; $display("FAIL miss_issue: r=%0b w=%0b a=%h want 1 0 20", mem_read, mem_write, mem_address); end
        checks++; if (log_addr.size() !== ln0 + 1 || dut.count !== 3'd1) begin
            errors++; $display("FAIL miss_after_pop: writes=%0d count=%0d want 1 1", log_addr.size() - ln0, dut.count); end
        while (c_busywait && n < 50) begin tick(); n++; end
        checks++; if (n !== 3) begin errors++; $display("FAIL miss_latency: cycles %0d want 3", n); end
        checks++; if (c_readdata !== 32'hCAFEF00D) begin errors++; $display("FAIL miss_data: got %h want cafef00d", c_readdata); end
        tick();
        checks++; if (c_busywait !== 1'b1) begin errors++; $display("FAIL miss_one_cycle: busywait=%0b want 1", c_busywait); end
        c_read = 1'b0;
        tick();
        checks++; if (mem_write !== 1'b1 || mem_address !== 6'h04) begin errors++; $display("FAIL miss_resume: w=%0b a=%h want 1 04", mem_write, mem_address); end
        drain_all();
        checks++; if (memarr[4] !== 32'h44444444) begin errors++; $display("FAIL miss_resume_mem: got %h want 44444444", memarr[4]); end
    endtask

    task automatic test_reset_mid_drain();
        hold_busy = 1'b1;
        wr(6'h11, 32'h11); tick();
        wr(6'h12, 32'h12); tick();
        wr(6'h13, 32'h13); tick(); c_write = 1'b0;
        checks++; if (dut.count !== 3'd3 || mem_write !== 1'b1) begin errors++; $display("FAIL rst_pre: count=%0d w=%0b want 3 1", dut.count, mem_write); end
        RESET = 1'b1; tick(); RESET = 1'b0;
        checks++; if (mem_write !== 1'b0 || mem_read !== 1'b0) begin errors++; $display("FAIL rst_mem_ctl: w=%0b r=%0b want 0 0", mem_write, mem_read); end
        checks++; if (mem_address !== 6'h0 || mem_writedata !== 32'h0) begin errors++; $display("FAIL rst_mem_bus: a=%h d=%h want 0 0", mem_address, mem_writedata); end
        checks++; if (dut.count !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", dut.count); end
        wr(6'h15, 32'h15);
        checks++; if (c_busywait !== 1'b0) begin errors++; $display("FAIL rst_new_write: busywait=%0b want 0", c_busywait); end
        tick(); c_write = 1'b0;
        drain_all();
    endtask

    initial begin
        RESET = 1'b1; c_read = 1'b0; c_write = 1'b0; c_address = '0; c_writedata = '0;
        hold_busy = 1'b0; lat = 0; rd_seen = 1'b0; both_seen = 1'b0;
        for (int i = 0; i < 64; i++) memarr[i] = 32'h0;
        test_reset();
        test_single_write();
        test_full();
        test_coalesce();
        test_read_hit();
        test_read_miss();
        test_reset_mid_drain();
        checks++; if (both_seen !== 1'b0) begin errors++; $display("FAIL rw_exclusive: both seen=%0b want 0", both_seen); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/dcache_write_buffer.md
Name: dcache_write_buffer

Overview:
Posted-write FIFO between the data cache and data_memory. It absorbs block write-backs from the cache so the cache does not stall for the full memory write latency. Buffered blocks drain to memory in FIFO order. Cache block reads either forward from matching buffered entries or pass through to memory, with priority over draining.

Parameters:
DEPTH, 4, number of buffered block entries (power of 2, at least 2)
ADDR_W, 6, block address width
DATA_W, 32, block data width (4 bytes)

Ports:
CLK  input  1  system clock; all state updates on rising edge
RESET  input  1  synchronous, active-high reset
c_read  input  1  cache block read request
c_write  input  1  cache block write-back request
c_address  input  ADDR_W  cache block address
c_writedata  input  DATA_W  write-back block
c_readdata  output  DATA_W  block returned to cache
c_busywait  output  1  stall to cache (combinational)
mem_read  output  1  read request to data_memory (registered)
mem_write  output  1  write request to data_memory (registered)
mem_address  output  ADDR_W  block address to data_memory (registered)
mem_writedata  output  DATA_W  block to data_memory (registered)
mem_readdata  input  DATA_W  block from data_memory
mem_busywait  input  1  data_memory stall

Behaviour:
- Storage: DEPTH entries {addr, data}, head/tail pointers, count 0..DEPTH. Pointers wrap modulo DEPTH.
- FSM states: IDLE, DRAIN, MEM_READ, READ_DONE.
- Reset, synchronous on RESET=1 at a rising edge:
  - state=IDLE; count=0; pointers=0.
  - mem_read=0, mem_write=0, mem_address=0, mem_writedata=0, c_readdata=0.
  - Any in-flight transaction is abandoned and buffered data is discarded.
- Write accept. Condition: c_write=1, c_read=0, and either count<DEPTH or a drain pop occurs this edge.
  - When accepted: c_busywait=0 and the write is absorbed at that edge, 1-cycle latency.
  - Coalesce: if c_address matches a valid entry other than the head currently in DRAIN, overwrite that entry's data; count unchanged.
  - Otherwise append at tail; count+1.
  - When full with no pop: c_busywait=1 and the cache holds its request.
- Read hit: c_read=1 and c_address matches any valid entry, including the draining head.
  - c_readdata is combinationally forwarded from the newest matching entry; c_busywait=0 the same cycle.
- Read miss: c_busywait=1.
  - From IDLE, go to MEM_READ. From DRAIN, finish the current write first, then go directly to MEM_READ; no further drain is started while the miss is pending.
  - In MEM_READ: mem_read=1, mem_address=c_address. The transaction completes at the first edge with mem_busywait=0. At that edge: capture mem_readdata into c_readdata, clear mem_read, go to READ_DONE.
  - READ_DONE: c_busywait=0 for exactly one cycle, then IDLE.
- Drain: in IDLE with count>0 and no read miss pending, go to DRAIN.
  - In DRAIN: mem_write=1; mem_address and mem_writedata come from the head entry.
  - Completes at the first edge with mem_write=1 and mem_busywait=0. At that edge: pop the head (count-1), drop mem_write, go to IDLE.
  - IDLE always lasts at least one cycle, so memory sees mem_write deasserted between transactions.
- Simultaneous pop and append at the same edge: count unchanged. This also holds when full.
- c_read and c_write both asserted is illegal. c_read takes precedence and the write is not accepted.
- mem_read and mem_write are never both 1.
- Ordering: a read miss may bypass pending writes, because a miss means no pending entry has a matching address.

Test Plan:
- RESET pulse mid-DRAIN (count=3) -> next cycle mem_write=0, count=0, c_busywait=0 for a new write, all mem_* outputs = 0.
- Write addr 0x05 data 0xAABBCCDD with an idle buffer -> c_busywait stays 0; within 2 cycles mem_write=1, mem_address=0x05, mem_writedata=0xAABBCCDD. With a 5-cycle memory, the entry pops and count returns to 0.
- Write 5 distinct addresses 0x01..0x05 back-to-back with mem_busywait held high -> first 4 accepted. The 5th sees c_busywait=1 until the first drain completes, then is accepted on the pop edge with count staying 4.
- Write 0x10 = 0x11111111, then write 0x10 = 0x22222222 while 0x10 is not the draining head -> count unchanged. Memory eventually receives only 0x22222222 at 0x10.
- Pending write 0x07 = 0xDEADBEEF, then c_read 0x07 -> c_readdata=0xDEADBEEF, c_busywait=0 the same cycle, mem_read never asserted.
- c_read 0x20 (miss) issued during DRAIN of 0x03 -> mem_read rises only after the 0x03 write completes. c_readdata = memory contents of 0x20; c_busywait is low exactly one cycle in READ_DONE; the drain then resumes.
